// File: rtl/pu_or1k_pkg.sv
// Shared encodings for the cappuccino writeback stage: LSU access lengths and WB FSM states.
package pu_or1k_pkg;

    localparam logic [1:0] LSU_BYTE = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_WORD = 2'b10;

    typedef enum logic {
        WB_IDLE,
        WB_LOAD_WAIT
    } wb_state_t;

endpackage

// File: rtl/pu_or1k_load_align.sv
// Big-endian load lane selection with sign/zero extension; length 11 falls through to word.
module pu_or1k_load_align
    import pu_or1k_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] i_dat,
    input  logic [1:0]   i_length,
    input  logic         i_zext,
    input  logic [1:0]   i_adr,
    output logic [W-1:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_fill;

    // Byte lane 0 is the most significant byte of the bus word; adr[0] is ignored for halves.
    always_comb begin
        w_byte = i_dat[7:0];
        case (i_adr)
            2'b00:   w_byte = i_dat[31:24];
            2'b01:   w_byte = i_dat[23:16];
            2'b10:   w_byte = i_dat[15:8];
            default: w_byte = i_dat[7:0];
        endcase
        w_half = i_adr[1] ? i_dat[15:0] : i_dat[31:16];
        w_fill = 1'b0;
        o_result = i_dat;
        case (i_length)
            LSU_BYTE: begin
                w_fill   = ~i_zext & w_byte[7];
                o_result = {{(W-8){w_fill}}, w_byte};
            end
            LSU_HALF: begin
                w_fill   = ~i_zext & w_half[15];
                o_result = {{(W-16){w_fill}}, w_half};
            end
            default: o_result = i_dat;
        endcase
    end

endmodule

// File: rtl/pu_or1k_wb_cappuccino.sv
// Cappuccino writeback stage: selects the ctrl-stage result, waits for late load data,
// and presents a held result/destination with a one-cycle RF write strobe.
module pu_or1k_wb_cappuccino
    import pu_or1k_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int OPTION_R0_IS_ZERO    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_wb_i,
    input  logic                            pipeline_flush_i,
    input  logic                            ctrl_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_mul_result_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_spr_dat_i,
    input  logic                            ctrl_op_lsu_load_i,
    input  logic                            ctrl_op_mul_i,
    input  logic                            ctrl_op_mfspr_i,
    input  logic [1:0]                      ctrl_lsu_length_i,
    input  logic                            ctrl_lsu_zext_i,
    input  logic [1:0]                      ctrl_lsu_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_dat_i,
    input  logic                            lsu_valid_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
    output logic                            wb_rf_wb_o,
    output logic                            wb_stall_o
);

    wb_state_t                       r_state;
    logic [OPTION_OPERAND_WIDTH-1:0] r_result;
    logic [OPTION_RF_ADDR_WIDTH-1:0] r_rfd_adr;
    logic                            r_rf_wb;
    logic [OPTION_RF_ADDR_WIDTH-1:0] r_ld_rfd_adr;
    logic                            r_ld_rf_wb;
    logic [1:0]                      r_ld_length;
    logic                            r_ld_zext;
    logic [1:0]                      r_ld_adr;

    logic                            w_wait;
    logic                            w_rf_wb_en;
    logic [OPTION_OPERAND_WIDTH-1:0] w_nonload_result;
    logic [OPTION_OPERAND_WIDTH-1:0] w_load_result;
    logic [1:0]                      w_al_length;
    logic                            w_al_zext;
    logic [1:0]                      w_al_adr;

    assign w_wait     = (r_state == WB_LOAD_WAIT);
    assign w_rf_wb_en = ctrl_rf_wb_i &
                        ~((OPTION_R0_IS_ZERO != 0) && (ctrl_rfd_adr_i == '0));

    assign w_nonload_result = ctrl_op_mfspr_i ? ctrl_spr_dat_i :
                              ctrl_op_mul_i   ? ctrl_mul_result_i :
                                                ctrl_alu_result_i;

    // While waiting, the aligner must use the controls latched when the load entered WB.
    assign w_al_length = w_wait ? r_ld_length : ctrl_lsu_length_i;
    assign w_al_zext   = w_wait ? r_ld_zext   : ctrl_lsu_zext_i;
    assign w_al_adr    = w_wait ? r_ld_adr    : ctrl_lsu_adr_i;

    pu_or1k_load_align #(
        .W(OPTION_OPERAND_WIDTH)
    ) u_load_align (
        .i_dat    (lsu_dat_i),
        .i_length (w_al_length),
        .i_zext   (w_al_zext),
        .i_adr    (w_al_adr),
        .o_result (w_load_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= WB_IDLE;
            r_result     <= '0;
            r_rfd_adr    <= '0;
            r_rf_wb      <= 1'b0;
            r_ld_rfd_adr <= '0;
            r_ld_rf_wb   <= 1'b0;
            r_ld_length  <= LSU_WORD;
            r_ld_zext    <= 1'b0;
            r_ld_adr     <= 2'b00;
        end else begin
            r_rf_wb <= 1'b0;
            case (r_state)
                WB_IDLE: begin
                    if (padv_wb_i && !pipeline_flush_i) begin
                        if (!ctrl_op_lsu_load_i) begin
                            r_result  <= w_nonload_result;
                            r_rfd_adr <= ctrl_rfd_adr_i;
                            r_rf_wb   <= w_rf_wb_en;
                        end else if (lsu_valid_i) begin
                            r_result  <= w_load_result;
                            r_rfd_adr <= ctrl_rfd_adr_i;
                            r_rf_wb   <= w_rf_wb_en;
                        end else begin
                            r_ld_rfd_adr <= ctrl_rfd_adr_i;
                            r_ld_rf_wb   <= w_rf_wb_en;
                            r_ld_length  <= ctrl_lsu_length_i;
                            r_ld_zext    <= ctrl_lsu_zext_i;
                            r_ld_adr     <= ctrl_lsu_adr_i;
                            r_state      <= WB_LOAD_WAIT;
                        end
                    end
                end
                WB_LOAD_WAIT: begin
                    if (pipeline_flush_i) begin
                        r_state <= WB_IDLE;
                    end else if (lsu_valid_i) begin
                        r_result  <= w_load_result;
                        r_rfd_adr <= r_ld_rfd_adr;
                        r_rf_wb   <= r_ld_rf_wb;
                        r_state   <= WB_IDLE;
                    end
                end
                default: r_state <= WB_IDLE;
            endcase
        end
    end

    assign result_o     = r_result;
    assign wb_rfd_adr_o = r_rfd_adr;
    assign wb_rf_wb_o   = r_rf_wb;
    assign wb_stall_o   = w_wait;

    a_no_advance_while_stalled: assert property (
        @(posedge clk) disable iff (!rst) !(w_wait && padv_wb_i)
    );

endmodule

// File: tb/tb_pu_or1k_wb_cappuccino.sv
// Directed bench for the cappuccino writeback stage; a second instance covers OPTION_R0_IS_ZERO=0.
module tb_pu_or1k_wb_cappuccino;

    logic        clk;
    logic        rst;
    logic        padvWb;
    logic        flush;
    logic        ctrlRfWb;
    logic [4:0]  ctrlRfdAdr;
    logic [31:0] aluResult;
    logic [31:0] mulResult;
    logic [31:0] sprDat;
    logic        opLoad;
    logic        opMul;
    logic        opMfspr;
    logic [1:0]  lsuLength;
    logic        lsuZext;
    logic [1:0]  lsuAdr;
    logic [31:0] lsuDat;
    logic        lsuValid;

    logic [31:0] resultO;
    logic [4:0]  rfdO;
    logic        rfWbO;
    logic        stallO;
    logic [31:0] resultR0;
    logic [4:0]  rfdR0;
    logic        rfWbR0;
    logic        stallR0;

    int testsRun    = 0;
    int testsFailed = 0;

    pu_or1k_wb_cappuccino #(
        .OPTION_OPERAND_WIDTH(32),
        .OPTION_RF_ADDR_WIDTH(5),
        .OPTION_R0_IS_ZERO(1)
    ) dut (
        .clk(clk), .rst(rst), .padv_wb_i(padvWb), .pipeline_flush_i(flush),
        .ctrl_rf_wb_i(ctrlRfWb), .ctrl_rfd_adr_i(ctrlRfdAdr),
        .ctrl_alu_result_i(aluResult), .ctrl_mul_result_i(mulResult), .ctrl_spr_dat_i(sprDat),
        .ctrl_op_lsu_load_i(opLoad), .ctrl_op_mul_i(opMul), .ctrl_op_mfspr_i(opMfspr),
        .ctrl_lsu_length_i(lsuLength), .ctrl_lsu_zext_i(lsuZext), .ctrl_lsu_adr_i(lsuAdr),
        .lsu_dat_i(lsuDat), .lsu_valid_i(lsuValid),
        .result_o(resultO), .wb_rfd_adr_o(rfdO), .wb_rf_wb_o(rfWbO), .wb_stall_o(stallO)
    );

    pu_or1k_wb_cappuccino #(
        .OPTION_OPERAND_WIDTH(32),
        .OPTION_RF_ADDR_WIDTH(5),
        .OPTION_R0_IS_ZERO(0)
    ) dutR0 (
        .clk(clk), .rst(rst), .padv_wb_i(padvWb), .pipeline_flush_i(flush),
        .ctrl_rf_wb_i(ctrlRfWb), .ctrl_rfd_adr_i(ctrlRfdAdr),
        .ctrl_alu_result_i(aluResult), .ctrl_mul_result_i(mulResult), .ctrl_spr_dat_i(sprDat),
        .ctrl_op_lsu_load_i(opLoad), .ctrl_op_mul_i(opMul), .ctrl_op_mfspr_i(opMfspr),
        .ctrl_lsu_length_i(lsuLength), .ctrl_lsu_zext_i(lsuZext), .ctrl_lsu_adr_i(lsuAdr),
        .lsu_dat_i(lsuDat), .lsu_valid_i(lsuValid),
        .result_o(resultR0), .wb_rfd_adr_o(rfdR0), .wb_rf_wb_o(rfWbR0), .wb_stall_o(stallR0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        padvWb = 0; flush = 0; ctrlRfWb = 0; ctrlRfdAdr = 0;
        aluResult = 0; mulResult = 0; sprDat = 0;
        opLoad = 0; opMul = 0; opMfspr = 0;
        lsuLength = 2'b10; lsuZext = 0; lsuAdr = 0; lsuDat = 0; lsuValid = 0;
    endtask

    task automatic aluOp(input logic [31:0] val, input logic [4:0] rfd);
        clearInputs();
        padvWb = 1; aluResult = val; ctrlRfdAdr = rfd; ctrlRfWb = 1;
        step();
        clearInputs();
    endtask

    task automatic test_reset();
        testsRun++;
        if ({resultO, rfdO, rfWbO, stallO} !== 39'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got result=%h rfd=%0d wb=%b stall=%b expected all zero",
                     resultO, rfdO, rfWbO, stallO);
        end
    endtask

    task automatic test_alu();
        aluOp(32'h1234_5678, 5'd3);
        testsRun++;
        if (resultO !== 32'h1234_5678 || rfdO !== 5'd3 || rfWbO !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL alu_capture: got result=%h rfd=%0d wb=%b expected 12345678/3/1",
                     resultO, rfdO, rfWbO);
        end
        step();
        testsRun++;
        if (rfWbO !== 1'b0 || resultO !== 32'h1234_5678) begin
            testsFailed++;
            $display("[TB] FAIL alu_single_strobe: got wb=%b result=%h expected 0/12345678", rfWbO, resultO);
        end
    endtask

    task automatic test_load_byte();
        logic [31:0] expected [2] = '{32'hFFFF_FF83, 32'h0000_0083};
        for (int z = 0; z < 2; z++) begin
            clearInputs();
            padvWb = 1; opLoad = 1; lsuLength = 2'b00; lsuZext = z[0]; lsuAdr = 2'd2;
            lsuDat = 32'h1122_8344; lsuValid = 1; ctrlRfdAdr = 5'd5; ctrlRfWb = 1;
            step();
            clearInputs();
            testsRun++;
            if (resultO !== expected[z] || rfWbO !== 1'b1 || stallO !== 1'b0 || rfdO !== 5'd5) begin
                testsFailed++;
                $display("[TB] FAIL load_byte_zext%0d: got result=%h wb=%b stall=%b rfd=%0d expected %h/1/0/5",
                         z, resultO, rfWbO, stallO, rfdO, expected[z]);
            end
            step();
            testsRun++;
            if (rfWbO !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL load_byte_strobe_drop%0d: got wb=%b expected 0", z, rfWbO);
            end
        end
    endtask

    task automatic test_load_wait();
        clearInputs();
        padvWb = 1; opLoad = 1; lsuLength = 2'b01; lsuZext = 0; lsuAdr = 2'd0;
        ctrlRfdAdr = 5'd7; ctrlRfWb = 1;
        step();
        clearInputs();
        // Scramble ctrl inputs: the captured value must come from the latched controls.
        lsuLength = 2'b00; lsuAdr = 2'd3; lsuZext = 1; ctrlRfdAdr = 5'd9;
        for (int i = 0; i < 3; i++) begin
            testsRun++;
            if (stallO !== 1'b1 || rfWbO !== 1'b0 || resultO !== 32'h0000_0083) begin
                testsFailed++;
                $display("[TB] FAIL load_wait_cycle%0d: got stall=%b wb=%b result=%h expected 1/0/00000083",
                         i, stallO, rfWbO, resultO);
            end
            if (i == 2) begin
                lsuValid = 1; lsuDat = 32'h1122_8344;
            end
            step();
        end
        lsuValid = 0;
        testsRun++;
        if (stallO !== 1'b0 || rfWbO !== 1'b1 || resultO !== 32'h0000_1122 || rfdO !== 5'd7) begin
            testsFailed++;
            $display("[TB] FAIL load_wait_capture: got stall=%b wb=%b result=%h rfd=%0d expected 0/1/00001122/7",
                     stallO, rfWbO, resultO, rfdO);
        end
        step();
        testsRun++;
        if (rfWbO !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL load_wait_single_strobe: got wb=%b expected 0", rfWbO);
        end
        clearInputs();
    endtask

    task automatic test_load_variants();
        logic [1:0]  lens [3] = '{2'b01, 2'b01, 2'b11};
        logic        zexts [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  adrs [3] = '{2'd3, 2'd2, 2'd1};
        logic [31:0] exps [3] = '{32'hFFFF_8344, 32'h0000_8344, 32'h1122_8344};
        for (int k = 0; k < 3; k++) begin
            clearInputs();
            padvWb = 1; opLoad = 1; lsuLength = lens[k]; lsuZext = zexts[k]; lsuAdr = adrs[k];
            lsuDat = 32'h1122_8344; lsuValid = 1; ctrlRfdAdr = 5'd12; ctrlRfWb = 1;
            step();
            clearInputs();
            testsRun++;
            if (resultO !== exps[k] || rfWbO !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL load_variant%0d: got result=%h wb=%b expected %h/1", k, resultO, rfWbO, exps[k]);
            end
        end
        step();
    endtask

    task automatic test_priority();
        clearInputs();
        padvWb = 1; opMfspr = 1; opMul = 1; sprDat = 32'hA; mulResult = 32'hB; aluResult = 32'hC;
        ctrlRfdAdr = 5'd8; ctrlRfWb = 1;
        step();
        testsRun++;
        if (resultO !== 32'hA) begin
            testsFailed++;
            $display("[TB] FAIL prio_mfspr_over_mul: got %h expected 0000000a", resultO);
        end
        opMfspr = 0;
        step();
        testsRun++;
        if (resultO !== 32'hB) begin
            testsFailed++;
            $display("[TB] FAIL prio_mul_over_alu: got %h expected 0000000b", resultO);
        end
        opMfspr = 1; opLoad = 1; lsuLength = 2'b00; lsuZext = 1; lsuAdr = 2'd0;
        lsuDat = 32'h1122_8344; lsuValid = 1;
        step();
        clearInputs();
        testsRun++;
        if (resultO !== 32'h11) begin
            testsFailed++;
            $display("[TB] FAIL prio_load_over_all: got %h expected 00000011", resultO);
        end
        step();
    endtask

    task automatic test_r0();
        aluOp(32'h55, 5'd0);
        testsRun++;
        if (rfWbO !== 1'b0 || resultO !== 32'h55) begin
            testsFailed++;
            $display("[TB] FAIL r0_masked: got wb=%b result=%h expected 0/00000055", rfWbO, resultO);
        end
        testsRun++;
        if (rfWbR0 !== 1'b1 || resultR0 !== 32'h55) begin
            testsFailed++;
            $display("[TB] FAIL r0_unmasked: got wb=%b result=%h expected 1/00000055", rfWbR0, resultR0);
        end
        step();
    endtask

    task automatic test_flush();
        aluOp(32'hCAFE, 5'd4);
        step();
        // Flush while waiting, data arrives the following cycle.
        padvWb = 1; opLoad = 1; ctrlRfdAdr = 5'd10; ctrlRfWb = 1;
        step();
        clearInputs();
        flush = 1;
        step();
        flush = 0; lsuValid = 1; lsuDat = 32'hDEAD_BEEF;
        testsRun++;
        if (stallO !== 1'b0 || rfWbO !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL flush_wait_exit: got stall=%b wb=%b expected 0/0", stallO, rfWbO);
        end
        step();
        lsuValid = 0;
        testsRun++;
        if (rfWbO !== 1'b0 || resultO !== 32'hCAFE || rfdO !== 5'd4) begin
            testsFailed++;
            $display("[TB] FAIL flush_late_data: got wb=%b result=%h rfd=%0d expected 0/0000cafe/4",
                     rfWbO, resultO, rfdO);
        end
        // Flush and data in the same cycle.
        padvWb = 1; opLoad = 1; ctrlRfdAdr = 5'd11; ctrlRfWb = 1;
        step();
        clearInputs();
        flush = 1; lsuValid = 1; lsuDat = 32'hDEAD_BEEF;
        step();
        clearInputs();
        testsRun++;
        if (rfWbO !== 1'b0 || stallO !== 1'b0 || resultO !== 32'hCAFE) begin
            testsFailed++;
            $display("[TB] FAIL flush_with_valid: got wb=%b stall=%b result=%h expected 0/0/0000cafe",
                     rfWbO, stallO, resultO);
        end
        // Flush and advance in the same cycle.
        padvWb = 1; flush = 1; aluResult = 32'hBEEF; ctrlRfdAdr = 5'd6; ctrlRfWb = 1;
        step();
        clearInputs();
        testsRun++;
        if (rfWbO !== 1'b0 || resultO !== 32'hCAFE || rfdO !== 5'd4) begin
            testsFailed++;
            $display("[TB] FAIL flush_with_padv: got wb=%b result=%h rfd=%0d expected 0/0000cafe/4",
                     rfWbO, resultO, rfdO);
        end
        // Stray data valid in IDLE with no load.
        lsuValid = 1; lsuDat = 32'h0BAD_0BAD;
        step();
        clearInputs();
        testsRun++;
        if (rfWbO !== 1'b0 || resultO !== 32'hCAFE) begin
            testsFailed++;
            $display("[TB] FAIL idle_valid_ignored: got wb=%b result=%h expected 0/0000cafe", rfWbO, resultO);
        end
    endtask

    task automatic test_back_to_back();
        clearInputs();
        padvWb = 1; aluResult = 32'h1; ctrlRfdAdr = 5'd1; ctrlRfWb = 1;
        step();
        aluResult = 32'h2; ctrlRfdAdr = 5'd2;
        testsRun++;
        if (rfWbO !== 1'b1 || resultO !== 32'h1 || rfdO !== 5'd1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_first: got wb=%b result=%h rfd=%0d expected 1/00000001/1", rfWbO, resultO, rfdO);
        end
        step();
        clearInputs();
        testsRun++;
        if (rfWbO !== 1'b1 || resultO !== 32'h2 || rfdO !== 5'd2) begin
            testsFailed++;
            $display("[TB] FAIL b2b_second: got wb=%b result=%h rfd=%0d expected 1/00000002/2", rfWbO, resultO, rfdO);
        end
        step();
        testsRun++;
        if (rfWbO !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_strobe_drop: got wb=%b expected 0", rfWbO);
        end
    endtask

    task automatic test_reset_mid_wait();
        clearInputs();
        padvWb = 1; opLoad = 1; ctrlRfdAdr = 5'd13; ctrlRfWb = 1;
        step();
        clearInputs();
        rst = 0;
        #1;
        testsRun++;
        if ({resultO, rfdO, rfWbO, stallO} !== 39'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_wait: got result=%h rfd=%0d wb=%b stall=%b expected all zero",
                     resultO, rfdO, rfWbO, stallO);
        end
        lsuValid = 1; lsuDat = 32'h1122_8344;
        step();
        rst = 1;
        step();
        clearInputs();
        testsRun++;
        if (rfWbO !== 1'b0 || stallO !== 1'b0 || resultO !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_valid_ignored: got wb=%b stall=%b result=%h expected 0/0/0",
                     rfWbO, stallO, resultO);
        end
    endtask

    initial begin
        rst = 0;
        clearInputs();
        step();
        step();
        test_reset();
        rst = 1;
        step();
        test_alu();
        test_load_byte();
        test_load_wait();
        test_load_variants();
        test_priority();
        test_r0();
        test_flush();
        test_back_to_back();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
